// File: rtl/huff_pkg.sv
// huff_pkg: shared constants, FSM encoding and length-to-mask table for the serial Huffman decoder.
package huff_pkg;
   localparam int NSYM   = 6;
   localparam int CODE_W = 8;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} state_t;
   // Entry n is the only mask a codeword of length n may carry.
   localparam logic [CODE_W:0][CODE_W-1:0] LEN_MASK = {
      8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00
   };
endpackage

// File: rtl/huff_code_match.sv
// huff_code_match: combinational compare of the candidate shift register against the code table.
// Ports: sr_n/len_n candidate bits and length; code/mask table; hit and idx (lowest matching symbol).
module huff_code_match
   import huff_pkg::*;
(
   input  logic [CODE_W-1:0]            sr_n,
   input  logic [3:0]                   len_n,
   input  logic [NSYM:1][CODE_W-1:0]    code,
   input  logic [NSYM:1][CODE_W-1:0]    mask,
   output logic                         hit,
   output logic [2:0]                   idx
);
   logic [CODE_W-1:0] want;
   always_comb begin
      want = LEN_MASK[len_n];
      hit  = 1'b0;
      idx  = 3'd0;
      // Descending scan so the lowest matching symbol is the one left standing.
      for (int i = NSYM; i >= 1; i--) begin
         if (mask[i] != '0 && mask[i] == want && (sr_n & mask[i]) == code[i]) begin
            hit = 1'b1;
            idx = 3'(i);
         end
      end
   end
endmodule

// File: rtl/huff_decoder.sv
// huff_decoder: serial Huffman decoder, one code bit per cycle MSB-first, table loaded by software.
// Ports: clk/reset (async, active-high); tbl_we/tbl_idx/tbl_code/tbl_mask table write; tbl_done ends load;
//        bit_valid/bit_in/bit_ready serial input; sym_valid/sym decoded symbol; err no-match pulse.
// Build option: define HUFF_DEC_ERR_EN to add the err port.
module huff_decoder
   import huff_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tbl_we,
   input  logic [2:0]  tbl_idx,
   input  logic [7:0]  tbl_code,
   input  logic [7:0]  tbl_mask,
   input  logic        tbl_done,
   input  logic        bit_valid,
   input  logic        bit_in,
   output logic        bit_ready,
   output logic        sym_valid,
   output logic [2:0]  sym
`ifdef HUFF_DEC_ERR_EN
   ,
   output logic        err
`endif
);
   state_t state_q, state_d;
   logic bit_ready_q, bit_ready_d, sym_valid_q, sym_valid_d;
   logic [2:0] sym_q, sym_d, hit_idx;
   // A stored prefix is at most 7 bits; an 8th bit always resolves to a match or a resync.
   logic [CODE_W-2:0] sr_q, sr_d;
   logic [3:0] len_q, len_d, len_n;
   logic [NSYM:1][CODE_W-1:0] code_q, code_d, mask_q, mask_d;
   logic [CODE_W-1:0] sr_n;
   logic accept, hit;
`ifdef HUFF_DEC_ERR_EN
   logic err_q, err_d;
`endif
   assign accept = bit_valid && bit_ready_q && !tbl_we;
   assign sr_n   = {sr_q, bit_in};
   assign len_n  = len_q + 4'd1;
   huff_code_match u_match (
      .sr_n  (sr_n),
      .len_n (len_n),
      .code  (code_q),
      .mask  (mask_q),
      .hit   (hit),
      .idx   (hit_idx)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = tbl_we ? ST_LOAD : (state_q == ST_LOAD && tbl_done) ? ST_RUN : state_q;
   end
   always_comb begin
      // Ready only once RUN has been held for a full cycle, and drops together with leaving RUN.
      bit_ready_d = state_q == ST_RUN && state_d == ST_RUN;
      code_d      = code_q;
      mask_d      = mask_q;
      if (tbl_we && tbl_idx >= 3'd1 && tbl_idx <= 3'(NSYM)) begin
         code_d[tbl_idx] = tbl_code;
         mask_d[tbl_idx] = tbl_mask;
      end
      sym_valid_d = 1'b0;
      sym_d       = sym_q;
      sr_d        = sr_q;
      len_d       = len_q;
`ifdef HUFF_DEC_ERR_EN
      err_d       = 1'b0;
`endif
      if (state_d == ST_LOAD) begin
         sr_d  = '0;
         len_d = '0;
      end else if (accept) begin
         sr_d  = sr_n[CODE_W-2:0];
         len_d = len_n;
         if (hit) begin
            sym_valid_d = 1'b1;
            sym_d       = hit_idx;
            sr_d        = '0;
            len_d       = '0;
         end else if (len_n == 4'd8) begin
            sr_d  = '0;
            len_d = '0;
`ifdef HUFF_DEC_ERR_EN
            err_d = 1'b1;
`endif
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_ready_q <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_q       <= '0;
         sr_q        <= '0;
         len_q       <= '0;
         code_q      <= '0;
         mask_q      <= '0;
      end else begin
         bit_ready_q <= bit_ready_d;
         sym_valid_q <= sym_valid_d;
         sym_q       <= sym_d;
         sr_q        <= sr_d;
         len_q       <= len_d;
         code_q      <= code_d;
         mask_q      <= mask_d;
      end
   end
`ifdef HUFF_DEC_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else err_q <= err_d;
   end
   assign err = err_q;
`endif
   assign bit_ready = bit_ready_q;
   assign sym_valid = sym_valid_q;
   assign sym       = sym_q;
endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder: directed stimulus with a codeword-level reference model and literal spot checks.
module tb_huff_decoder;
   logic clk = 1'b0;
   logic reset, tbl_we, tbl_done, bit_valid, bit_in;
   logic [2:0] tbl_idx;
   logic [7:0] tbl_code, tbl_mask;
   logic bit_ready, sym_valid;
   logic [2:0] sym;
`ifdef HUFF_DEC_ERR_EN
   logic err;
`endif
   int n_chk = 0;
   int n_fail = 0;
   int log_q[$];
   // Reference model state: table as (length, code), accumulated bits as an integer.
   int mode, m_sym, acc_val, acc_cnt;
   bit m_ready, m_valid, m_err;
   int t_code[1:6];
   int t_len[1:6];

   huff_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .tbl_we    (tbl_we),
      .tbl_idx   (tbl_idx),
      .tbl_code  (tbl_code),
      .tbl_mask  (tbl_mask),
      .tbl_done  (tbl_done),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_ready (bit_ready),
      .sym_valid (sym_valid),
      .sym       (sym)
`ifdef HUFF_DEC_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Length of a right-aligned run of ones; 0 means the entry can never match.
   function automatic int mask_len(input logic [7:0] m);
      for (int l = 1; l <= 8; l++) if (int'(m) == (1 << l) - 1) return l;
      return 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      int nmode, hit, av, ac;
      bit take, v, e;
      if (reset) begin
         mode <= 0; m_ready <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_sym <= 0;
         acc_val <= 0; acc_cnt <= 0;
         for (int i = 1; i <= 6; i++) begin
            t_code[i] <= 0;
            t_len[i] <= 0;
         end
      end else begin
         take  = bit_valid && m_ready && !tbl_we;
         nmode = tbl_we ? 1 : (mode == 1 && tbl_done) ? 2 : mode;
         av = acc_val; ac = acc_cnt; v = 1'b0; e = 1'b0;
         if (tbl_we && tbl_idx >= 1 && tbl_idx <= 6) begin
            t_code[tbl_idx] <= int'(tbl_code);
            t_len[tbl_idx]  <= mask_len(tbl_mask);
         end
         if (nmode == 1) begin
            av = 0; ac = 0;
         end else if (take) begin
            av = av * 2 + int'(bit_in);
            ac = ac + 1;
            hit = 0;
            for (int i = 6; i >= 1; i--) if (t_len[i] == ac && t_code[i] == av) hit = i;
            if (hit != 0) begin
               v = 1'b1; m_sym <= hit; av = 0; ac = 0;
            end else if (ac == 8) begin
               e = 1'b1; av = 0; ac = 0;
            end
         end
         m_ready <= (mode == 2 && nmode == 2);
         m_valid <= v;
         m_err   <= e;
         acc_val <= av;
         acc_cnt <= ac;
         mode    <= nmode;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("bit_ready", int'(bit_ready), int'(m_ready));
         chk("sym_valid", int'(sym_valid), int'(m_valid));
         chk("sym", int'(sym), m_sym);
`ifdef HUFF_DEC_ERR_EN
         chk("err", int'(err), int'(m_err));
`endif
         if (sym_valid) log_q.push_back(int'(sym));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int i, input logic [7:0] c, input logic [7:0] m);
      tbl_we = 1'b1; tbl_idx = 3'(i); tbl_code = c; tbl_mask = m;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic done();
      tbl_done = 1'b1;
      tick();
      tbl_done = 1'b0;
   endtask

   task automatic send(input logic b);
      bit_valid = 1'b1; bit_in = b;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s2_bits[20] = '{1, 0,1, 0,0,1, 0,0,0,1, 0,0,0,0,1, 0,0,0,0,0};
      int s2_sym[20]  = '{1, 0,2, 0,0,3, 0,0,0,4, 0,0,0,0,5, 0,0,0,0,6};
      reset = 1'b1; tbl_we = 1'b0; tbl_done = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      tbl_idx = '0; tbl_code = '0; tbl_mask = '0;
      tick(); tick();
      reset = 1'b0;
      // 1: reset state, load, ready two cycles after tbl_done
      chk("s1_rst_ready", int'(bit_ready), 0);
      chk("s1_rst_valid", int'(sym_valid), 0);
      chk("s1_rst_sym", int'(sym), 0);
      load(1, 8'h01, 8'h01); load(2, 8'h01, 8'h03); load(3, 8'h01, 8'h07);
      load(4, 8'h01, 8'h0F); load(5, 8'h01, 8'h1F); load(6, 8'h00, 8'h1F);
      chk("s1_load_ready", int'(bit_ready), 0);
      done();
      chk("s1_ready_d1", int'(bit_ready), 0);
      tick();
      chk("s1_ready_d2", int'(bit_ready), 1);
      // 2: all six codewords back-to-back
      log_q.delete();
      for (int k = 0; k < 20; k++) begin
         send(1'(s2_bits[k]));
         chk("s2_valid", int'(sym_valid), s2_sym[k] != 0 ? 1 : 0);
         if (s2_sym[k] != 0) chk("s2_sym", int'(sym), s2_sym[k]);
      end
      bit_valid = 1'b0;
      tick();
      chk("s2_count", log_q.size(), 6);
      for (int j = 0; j < 6 && j < log_q.size(); j++) chk("s2_order", log_q[j], j + 1);
      // 3: one-bit codewords give consecutive pulses
      for (int k = 0; k < 3; k++) begin
         send(1'b1);
         chk("s3_valid", int'(sym_valid), 1);
         chk("s3_sym", int'(sym), 1);
      end
      bit_valid = 1'b0;
      tick();
      chk("s3_gap", int'(sym_valid), 0);
      // 4: unused sym6, eight zeros resync, then a clean symbol
      load(6, 8'h00, 8'h00);
      done(); tick();
      for (int k = 0; k < 8; k++) begin
         send(1'b0);
         chk("s4_valid", int'(sym_valid), 0);
`ifdef HUFF_DEC_ERR_EN
         chk("s4_err", int'(err), k == 7 ? 1 : 0);
`endif
      end
      send(1'b1);
      chk("s4_after_valid", int'(sym_valid), 1);
      chk("s4_after_sym", int'(sym), 1);
      bit_valid = 1'b0;
      // 5: reload coinciding with a bit drops it and clears the prefix
      load(6, 8'h00, 8'h1F);
      done(); tick();
      send(1'b0); send(1'b0);
      tbl_we = 1'b1; tbl_idx = 3'd3; tbl_code = 8'h01; tbl_mask = 8'h07; bit_in = 1'b1;
      tick();
      tbl_we = 1'b0; bit_valid = 1'b0;
      chk("s5_drop_valid", int'(sym_valid), 0);
      chk("s5_drop_ready", int'(bit_ready), 0);
      done(); tick();
      chk("s5_ready", int'(bit_ready), 1);
      send(1'b1);
      chk("s5_valid", int'(sym_valid), 1);
      chk("s5_sym", int'(sym), 1);
      // 6: reset mid-codeword, then bits with no reload are ignored
      send(1'b0); send(1'b0); send(1'b0);
      reset = 1'b1;
      #1;
      chk("s6_rst_ready", int'(bit_ready), 0);
      chk("s6_rst_valid", int'(sym_valid), 0);
      chk("s6_rst_sym", int'(sym), 0);
      tick(); tick();
      reset = 1'b0;
      bit_in = 1'b1;
      tbl_done = 1'b1;
      tick();
      tbl_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("s6_ign_valid", int'(sym_valid), 0);
         chk("s6_ign_ready", int'(bit_ready), 0);
      end
      bit_valid = 1'b0;
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
